// File: rtl/shotclock_alarm_if.sv
// Signal bundle between the shot-clock counter/debounce stage, the alarm block,
// and the buzzer pin / seven-segment mux.
interface shotclock_alarm_if #(
    parameter int VCNT_W = 4
);
    logic              zero;
    logic              load;
    logic              ack;
    logic              buzzer;
    logic              blank;
    logic              alarm_active;
    logic [VCNT_W-1:0] violations;

    // Upstream/controller side: drives the counter status and pulses.
    modport master (
        output zero, load, ack,
        input  buzzer, blank, alarm_active, violations
    );

    // Alarm block side.
    modport slave (
        input  zero, load, ack,
        output buzzer, blank, alarm_active, violations
    );
endinterface

// File: rtl/shotclock_alarm.sv
// Shot-clock expiry alarm: on each rising edge of the counter's zero flag, plays
// NUM_BEEPS tone bursts separated by silent gaps, flashes the display during gaps,
// and keeps a saturating count of violations. load or ack cancels the alarm.
module shotclock_alarm #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TONE_HZ   = 2_000,
    parameter int BEEP_MS   = 250,
    parameter int GAP_MS    = 250,
    parameter int NUM_BEEPS = 3,
    parameter int VCNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    shotclock_alarm_if.slave   bus
);
    localparam int HALF     = CLK_HZ / (2 * TONE_HZ);
    localparam int BEEP_CYC = CLK_HZ / 1000 * BEEP_MS;
    localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
    localparam int TMR_MAX  = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    // Down-counters hold at most (cycles - 1); keep at least one bit.
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int TONE_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BL_W     = $clog2(NUM_BEEPS + 1);

    generate
        if (HALF < 1 || BEEP_CYC < 1 || GAP_CYC < 1 || NUM_BEEPS < 1) begin : g_bad_params
            $error("shotclock_alarm: derived HALF/BEEP_CYC/GAP_CYC or NUM_BEEPS below 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BEEP,
        GAP,
        HOLD
    } state_t;

    state_t            state;
    logic              zero_q;
    logic [TMR_W-1:0]  tmr;
    logic [TONE_W-1:0] tone_cnt;
    logic [BL_W-1:0]   beeps_left;
    logic              buzzer_q;
    logic              blank_q;
    logic              active_q;
    logic [VCNT_W-1:0] violations_q;
    logic              expiry;

    assign expiry = bus.zero && !zero_q;

    assign bus.buzzer       = buzzer_q;
    assign bus.blank        = blank_q;
    assign bus.alarm_active = active_q;
    assign bus.violations   = violations_q;

    // Alarm sequencer: state, timers, tone generator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            zero_q       <= 1'b1;
            tmr          <= '0;
            tone_cnt     <= '0;
            beeps_left   <= '0;
            buzzer_q     <= 1'b0;
            blank_q      <= 1'b0;
            active_q     <= 1'b0;
            violations_q <= '0;
        end else begin
            zero_q <= bus.zero;
            // load cancels everywhere and masks a coincident expiry; ack only
            // cancels outside IDLE so an expiry alongside it in IDLE still starts.
            if (bus.load || (bus.ack && state != IDLE)) begin
                state    <= IDLE;
                buzzer_q <= 1'b0;
                blank_q  <= 1'b0;
                active_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (expiry) begin
                            state      <= BEEP;
                            beeps_left <= BL_W'(NUM_BEEPS);
                            tmr        <= TMR_W'(BEEP_CYC - 1);
                            tone_cnt   <= TONE_W'(HALF - 1);
                            buzzer_q   <= 1'b1;
                            blank_q    <= 1'b0;
                            active_q   <= 1'b1;
                            if (violations_q != '1) begin
                                violations_q <= violations_q + VCNT_W'(1);
                            end
                        end
                    end
                    BEEP: begin
                        if (tmr == '0) begin
                            beeps_left <= beeps_left - BL_W'(1);
                            buzzer_q   <= 1'b0;
                            if (beeps_left > BL_W'(1)) begin
                                state   <= GAP;
                                tmr     <= TMR_W'(GAP_CYC - 1);
                                blank_q <= 1'b1;
                            end else begin
                                state   <= HOLD;
                                blank_q <= 1'b0;
                            end
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                            if (tone_cnt == '0) begin
                                tone_cnt <= TONE_W'(HALF - 1);
                                buzzer_q <= ~buzzer_q;
                            end else begin
                                tone_cnt <= tone_cnt - TONE_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (tmr == '0) begin
                            state    <= BEEP;
                            tmr      <= TMR_W'(BEEP_CYC - 1);
                            tone_cnt <= TONE_W'(HALF - 1);
                            buzzer_q <= 1'b1;
                            blank_q  <= 1'b0;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                    HOLD: begin
                        buzzer_q <= 1'b0;
                        blank_q  <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        buzzer_q <= 1'b0;
                        blank_q  <= 1'b0;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_shotclock_alarm.sv
// Directed bench for shotclock_alarm with small timing constants:
// HALF=5, BEEP_CYC=20, GAP_CYC=10, NUM_BEEPS=3, VCNT_W=4.
module tb_shotclock_alarm;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    shotclock_alarm_if #(.VCNT_W(4)) bus ();

    shotclock_alarm #(
        .CLK_HZ   (1000),
        .TONE_HZ  (100),
        .BEEP_MS  (20),
        .GAP_MS   (10),
        .NUM_BEEPS(3),
        .VCNT_W   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Packed view of outputs: {buzzer, blank, alarm_active, violations[3:0]}
    function automatic logic [31:0] outs();
        return {25'd0, bus.buzzer, bus.blank, bus.alarm_active, bus.violations};
    endfunction

    function automatic logic [31:0] mk(input logic bz, input logic bl, input logic act,
                                       input int v);
        logic [3:0] vv;
        vv = 4'(v);
        return {25'd0, bz, bl, act, vv};
    endfunction

    initial begin
        passed   = 0;
        total    = 0;
        rst_n    = 1'b0;
        bus.zero = 1'b1;
        bus.load = 1'b0;
        bus.ack  = 1'b0;

        // Reset state, zero held high through release.
        tick(2);
        chk("reset_outs", outs(), mk(0, 0, 0, 0));
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("t1_no_alarm", outs(), mk(0, 0, 0, 0));
        end

        // First expiry and the full burst.
        bus.zero = 1'b0;
        tick(1);
        bus.zero = 1'b1;
        tick(1);
        chk("t2_start", outs(), mk(1, 0, 1, 1));
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 20; c++) begin
                chk("t2_beep", outs(), mk(((c / 5) % 2) == 0, 0, 1, 1));
                tick(1);
            end
            if (b < 2) begin
                for (int g = 0; g < 10; g++) begin
                    chk("t2_gap", outs(), mk(0, 1, 1, 1));
                    tick(1);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold", outs(), mk(0, 0, 1, 1));
            tick(1);
        end

        // ack in HOLD returns to IDLE; re-arm and start a second burst.
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
        chk("t4_ack_hold", outs(), mk(0, 0, 0, 1));
        bus.zero = 1'b0;
        tick(1);
        bus.zero = 1'b1;
        tick(1);
        chk("t4_second", outs(), mk(1, 0, 1, 2));

        // Re-expiry during the burst is ignored (now beep1 cycle 2).
        bus.zero = 1'b0;
        tick(1);
        bus.zero = 1'b1;
        tick(1);
        chk("t4_reexpiry", outs(), mk(1, 0, 1, 2));

        // load at cycle 7 of beep 2.
        tick(28);
        chk("t3_beep2_c0", outs(), mk(1, 0, 1, 2));
        tick(7);
        chk("t3_beep2_c7", outs(), mk(0, 0, 1, 2));
        bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        chk("t3_load", outs(), mk(0, 0, 0, 2));

        // ack in IDLE is a no-op.
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
        chk("t4_ack_idle", outs(), mk(0, 0, 0, 2));

        // Expiry coincident with load is ignored.
        bus.zero = 1'b0;
        tick(1);
        bus.zero = 1'b1;
        bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
        chk("t5_load_mask", outs(), mk(0, 0, 0, 2));
        tick(1);
        chk("t5_load_mask2", outs(), mk(0, 0, 0, 2));

        // 17 expiries with ack between: count saturates at 15.
        for (int i = 0; i < 17; i++) begin
            bus.zero = 1'b0;
            tick(1);
            bus.zero = 1'b1;
            tick(1);
            chk("t5_sat", outs(), mk(1, 0, 1, (3 + i > 15) ? 15 : 3 + i));
            bus.ack = 1'b1;
            tick(1);
            bus.ack = 1'b0;
        end

        // Expiry coincident with ack in IDLE still starts the alarm.
        bus.zero = 1'b0;
        tick(1);
        bus.zero = 1'b1;
        bus.ack  = 1'b1;
        tick(1);
        bus.ack = 1'b0;
        chk("t4_ack_expiry", outs(), mk(1, 0, 1, 15));

        // Reset during a gap.
        tick(20);
        chk("t6_gap_c0", outs(), mk(0, 1, 1, 15));
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("t6_reset", outs(), mk(0, 0, 0, 0));
        for (int i = 0; i < 30; i++) begin
            tick(1);
            chk("t6_no_alarm", outs(), mk(0, 0, 0, 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
